// File: rtl/slc3_isdu_if.sv
// Control/status bundle between the SLC-3 ISDU (master) and the datapath (slave).
interface slc3_isdu_if;
  logic       Run;
  logic       Continue;
  logic [3:0] Opcode;
  logic       IR_5;
  logic       IR_11;
  logic       BEN;

  logic       LD_MAR;
  logic       LD_MDR;
  logic       LD_IR;
  logic       LD_BEN;
  logic       LD_CC;
  logic       LD_REG;
  logic       LD_PC;
  logic       LD_LED;
  logic       GatePC;
  logic       GateMDR;
  logic       GateALU;
  logic       GateMARMUX;
  logic [1:0] PCMUX;
  logic       DRMUX;
  logic       SR1MUX;
  logic       SR2MUX;
  logic       ADDR1MUX;
  logic [1:0] ADDR2MUX;
  logic [1:0] ALUK;
  logic       MIO_EN;
  logic       Mem_RD;
  logic       Mem_WR;
  logic       Halted;

  modport master (
    input  Run, Continue, Opcode, IR_5, IR_11, BEN,
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
           GatePC, GateMDR, GateALU, GateMARMUX,
           PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
           MIO_EN, Mem_RD, Mem_WR, Halted
  );

  modport slave (
    output Run, Continue, Opcode, IR_5, IR_11, BEN,
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
           GatePC, GateMDR, GateALU, GateMARMUX,
           PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
           MIO_EN, Mem_RD, Mem_WR, Halted
  );
endinterface

// File: rtl/slc3_isdu.sv
// SLC-3 instruction sequence/decode unit: Moore FSM driving all datapath controls.
// Define SLC3_ISDU_IR_PAUSE_EN to stop after every IR load for single-step inspection.
module slc3_isdu #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  slc3_isdu_if.master  bus
);

  typedef enum logic [4:0] {
    S_HALTED,
    S_F_MAR,
    S_F_RD,
    S_F_IR,
`ifdef SLC3_ISDU_IR_PAUSE_EN
    S_IRP1,
    S_IRP2,
`endif
    S_DECODE,
    S_ADD,
    S_AND,
    S_NOT,
    S_BR,
    S_BR_T,
    S_JMP,
    S_JSR,
    S_JSR_PC,
    S_LDR_A,
    S_LDR_RD,
    S_LDR_WB,
    S_STR_A,
    S_STR_D,
    S_STR_WR,
    S_PAUSE1,
    S_PAUSE2
  } state_t;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);

  state_t     state_reg, state_next;
  logic [2:0] wait_cnt_reg, wait_cnt_next;
  logic       mem_done;

  assign mem_done = (wait_cnt_reg == WAIT_LAST);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg    <= S_HALTED;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = '0;

    bus.LD_MAR     = 1'b0;
    bus.LD_MDR     = 1'b0;
    bus.LD_IR      = 1'b0;
    bus.LD_BEN     = 1'b0;
    bus.LD_CC      = 1'b0;
    bus.LD_REG     = 1'b0;
    bus.LD_PC      = 1'b0;
    bus.LD_LED     = 1'b0;
    bus.GatePC     = 1'b0;
    bus.GateMDR    = 1'b0;
    bus.GateALU    = 1'b0;
    bus.GateMARMUX = 1'b0;
    bus.PCMUX      = 2'd0;
    bus.DRMUX      = 1'b0;
    bus.SR1MUX     = 1'b0;
    bus.SR2MUX     = 1'b0;
    bus.ADDR1MUX   = 1'b0;
    bus.ADDR2MUX   = 2'd0;
    bus.ALUK       = 2'd0;
    bus.MIO_EN     = 1'b0;
    bus.Mem_RD     = 1'b0;
    bus.Mem_WR     = 1'b0;
    bus.Halted     = 1'b0;

    unique case (state_reg)
      S_HALTED: begin
        bus.Halted = 1'b1;
        if (bus.Run) state_next = S_F_MAR;
      end

      S_F_MAR: begin
        bus.GatePC = 1'b1;
        bus.LD_MAR = 1'b1;
        bus.LD_PC  = 1'b1;
        state_next = S_F_RD;
      end

      // Memory states hold the strobe until the wait counter reaches its last count;
      // the counter only runs inside these states, so it is zero on every entry.
      S_F_RD: begin
        bus.Mem_RD = 1'b1;
        bus.MIO_EN = 1'b1;
        bus.LD_MDR = 1'b1;
        if (mem_done) state_next = S_F_IR;
        else          wait_cnt_next = wait_cnt_reg + 3'd1;
      end

      S_F_IR: begin
        bus.GateMDR = 1'b1;
        bus.LD_IR   = 1'b1;
`ifdef SLC3_ISDU_IR_PAUSE_EN
        state_next  = S_IRP1;
`else
        state_next  = S_DECODE;
`endif
      end

`ifdef SLC3_ISDU_IR_PAUSE_EN
      S_IRP1: begin
        bus.LD_LED = 1'b1;
        if (bus.Continue) state_next = S_IRP2;
      end

      S_IRP2: begin
        if (!bus.Continue) state_next = S_DECODE;
      end
`endif

      S_DECODE: begin
        bus.LD_BEN = 1'b1;
        case (bus.Opcode)
          4'b0001: state_next = S_ADD;
          4'b0101: state_next = S_AND;
          4'b1001: state_next = S_NOT;
          4'b0000: state_next = S_BR;
          4'b1100: state_next = S_JMP;
          4'b0100: state_next = S_JSR;
          4'b0110: state_next = S_LDR_A;
          4'b0111: state_next = S_STR_A;
          4'b1101: state_next = S_PAUSE1;
          default: state_next = S_F_MAR;
        endcase
      end

      S_ADD, S_AND, S_NOT: begin
        bus.SR1MUX  = 1'b1;
        bus.SR2MUX  = bus.IR_5;
        bus.GateALU = 1'b1;
        bus.LD_REG  = 1'b1;
        bus.LD_CC   = 1'b1;
        if (state_reg == S_AND)      bus.ALUK = 2'd1;
        else if (state_reg == S_NOT) bus.ALUK = 2'd2;
        state_next = S_F_MAR;
      end

      S_BR: begin
        state_next = bus.BEN ? S_BR_T : S_F_MAR;
      end

      S_BR_T: begin
        bus.ADDR2MUX = 2'd2;
        bus.PCMUX    = 2'd1;
        bus.LD_PC    = 1'b1;
        state_next   = S_F_MAR;
      end

      S_JMP: begin
        bus.SR1MUX   = 1'b1;
        bus.ADDR1MUX = 1'b1;
        bus.PCMUX    = 2'd1;
        bus.LD_PC    = 1'b1;
        state_next   = S_F_MAR;
      end

      // R7 is written before the PC moves so it captures the return address.
      S_JSR: begin
        bus.GatePC = 1'b1;
        bus.DRMUX  = 1'b1;
        bus.LD_REG = 1'b1;
        state_next = S_JSR_PC;
      end

      S_JSR_PC: begin
        if (bus.IR_11) begin
          bus.ADDR2MUX = 2'd3;
        end else begin
          bus.ADDR1MUX = 1'b1;
          bus.SR1MUX   = 1'b1;
        end
        bus.PCMUX  = 2'd1;
        bus.LD_PC  = 1'b1;
        state_next = S_F_MAR;
      end

      S_LDR_A, S_STR_A: begin
        bus.SR1MUX     = 1'b1;
        bus.ADDR1MUX   = 1'b1;
        bus.ADDR2MUX   = 2'd1;
        bus.GateMARMUX = 1'b1;
        bus.LD_MAR     = 1'b1;
        state_next     = (state_reg == S_LDR_A) ? S_LDR_RD : S_STR_D;
      end

      S_LDR_RD: begin
        bus.Mem_RD = 1'b1;
        bus.MIO_EN = 1'b1;
        bus.LD_MDR = 1'b1;
        if (mem_done) state_next = S_LDR_WB;
        else          wait_cnt_next = wait_cnt_reg + 3'd1;
      end

      S_LDR_WB: begin
        bus.GateMDR = 1'b1;
        bus.LD_REG  = 1'b1;
        bus.LD_CC   = 1'b1;
        state_next  = S_F_MAR;
      end

      // Source register passes straight through the ALU into MDR.
      S_STR_D: begin
        bus.ALUK    = 2'd3;
        bus.GateALU = 1'b1;
        bus.LD_MDR  = 1'b1;
        state_next  = S_STR_WR;
      end

      S_STR_WR: begin
        bus.Mem_WR = 1'b1;
        if (mem_done) state_next = S_F_MAR;
        else          wait_cnt_next = wait_cnt_reg + 3'd1;
      end

      S_PAUSE1: begin
        bus.LD_LED = 1'b1;
        if (bus.Continue) state_next = S_PAUSE2;
      end

      S_PAUSE2: begin
        if (!bus.Continue) state_next = S_F_MAR;
      end

      default: state_next = S_HALTED;
    endcase
  end

endmodule

// File: tb/tb_slc3_isdu.sv
// Scoreboard bench for slc3_isdu: the stimulus queues hand-derived control words, a monitor checks them.
module tb_slc3_isdu;

  localparam int MW = 2;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  slc3_isdu_if bus ();

  slc3_isdu #(.MEM_WAIT(MW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic       gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic       drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic       mio_en, mem_rd, mem_wr, halted;
  } ctl_t;

  typedef enum {
    T_HALT, T_FMAR, T_FRD, T_FIR, T_IRP1, T_IRP2, T_DEC,
    T_ADD, T_AND, T_NOT, T_BR, T_BRT, T_JMP, T_JSR, T_JSRPC,
    T_LDRA, T_LDRRD, T_LDRWB, T_STRA, T_STRD, T_STRWR, T_PAUSE1, T_PAUSE2
  } tag_t;

  typedef struct {
    ctl_t e;
    tag_t t;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  event poke;

  // Hand-written control word for each state as listed in the state table.
  function automatic ctl_t expect_of(tag_t t, logic ir5, logic ir11);
    ctl_t e;
    e = '0;
    case (t)
      T_HALT:  e.halted = 1'b1;
      T_FMAR:  begin e.gate_pc = 1'b1; e.ld_mar = 1'b1; e.ld_pc = 1'b1; end
      T_FRD, T_LDRRD: begin e.mem_rd = 1'b1; e.mio_en = 1'b1; e.ld_mdr = 1'b1; end
      T_FIR:   begin e.gate_mdr = 1'b1; e.ld_ir = 1'b1; end
      T_IRP1, T_PAUSE1: e.ld_led = 1'b1;
      T_DEC:   e.ld_ben = 1'b1;
      T_ADD:   begin e.sr1mux = 1'b1; e.sr2mux = ir5; e.gate_alu = 1'b1; e.ld_reg = 1'b1; e.ld_cc = 1'b1; end
      T_AND:   begin e.sr1mux = 1'b1; e.sr2mux = ir5; e.gate_alu = 1'b1; e.ld_reg = 1'b1; e.ld_cc = 1'b1; e.aluk = 2'd1; end
      T_NOT:   begin e.sr1mux = 1'b1; e.sr2mux = ir5; e.gate_alu = 1'b1; e.ld_reg = 1'b1; e.ld_cc = 1'b1; e.aluk = 2'd2; end
      T_BRT:   begin e.addr2mux = 2'd2; e.pcmux = 2'd1; e.ld_pc = 1'b1; end
      T_JMP:   begin e.sr1mux = 1'b1; e.addr1mux = 1'b1; e.pcmux = 2'd1; e.ld_pc = 1'b1; end
      T_JSR:   begin e.gate_pc = 1'b1; e.drmux = 1'b1; e.ld_reg = 1'b1; end
      T_JSRPC: begin
        e.pcmux = 2'd1; e.ld_pc = 1'b1;
        if (ir11) e.addr2mux = 2'd3;
        else begin e.addr1mux = 1'b1; e.sr1mux = 1'b1; end
      end
      T_LDRA, T_STRA: begin e.sr1mux = 1'b1; e.addr1mux = 1'b1; e.addr2mux = 2'd1; e.gate_marmux = 1'b1; e.ld_mar = 1'b1; end
      T_LDRWB: begin e.gate_mdr = 1'b1; e.ld_reg = 1'b1; e.ld_cc = 1'b1; end
      T_STRD:  begin e.aluk = 2'd3; e.gate_alu = 1'b1; e.ld_mdr = 1'b1; end
      T_STRWR: e.mem_wr = 1'b1;
      default: e = '0;
    endcase
    return e;
  endfunction

  function automatic ctl_t sample_dut();
    ctl_t a;
    a.ld_mar = bus.LD_MAR;   a.ld_mdr = bus.LD_MDR;   a.ld_ir = bus.LD_IR;   a.ld_ben = bus.LD_BEN;
    a.ld_cc = bus.LD_CC;     a.ld_reg = bus.LD_REG;   a.ld_pc = bus.LD_PC;   a.ld_led = bus.LD_LED;
    a.gate_pc = bus.GatePC;  a.gate_mdr = bus.GateMDR; a.gate_alu = bus.GateALU; a.gate_marmux = bus.GateMARMUX;
    a.pcmux = bus.PCMUX;     a.drmux = bus.DRMUX;     a.sr1mux = bus.SR1MUX; a.sr2mux = bus.SR2MUX;
    a.addr1mux = bus.ADDR1MUX; a.addr2mux = bus.ADDR2MUX; a.aluk = bus.ALUK;
    a.mio_en = bus.MIO_EN;   a.mem_rd = bus.Mem_RD;   a.mem_wr = bus.Mem_WR; a.halted = bus.Halted;
    return a;
  endfunction

  function automatic void push(tag_t t);
    exp_t x;
    x.e = expect_of(t, bus.IR_5, bus.IR_11);
    x.t = t;
    sb.push_back(x);
  endfunction

  // Expect the state entered at the next rising edge.
  task automatic expect_next(tag_t t);
    @(posedge Clk);
    #1;
    push(t);
  endtask

  // Expect the current state immediately, between edges.
  task automatic expect_now(tag_t t);
    push(t);
    -> poke;
  endtask

  task automatic fetch();
    repeat (MW) expect_next(T_FRD);
    expect_next(T_FIR);
`ifdef SLC3_ISDU_IR_PAUSE_EN
    expect_next(T_IRP1);
    bus.Continue = 1'b1;
    expect_next(T_IRP2);
    bus.Continue = 1'b0;
`endif
    expect_next(T_DEC);
  endtask

  task automatic set_ir(logic [3:0] op, logic ir5, logic ir11, logic ben);
    bus.Opcode = op;
    bus.IR_5   = ir5;
    bus.IR_11  = ir11;
    bus.BEN    = ben;
  endtask

  // Monitor: checks queued expectations and the single-bus-driver rule.
  initial begin
    ctl_t a;
    exp_t x;
    int   g;
    forever begin
      @(negedge Clk or poke);
      a = sample_dut();
      g = int'(a.gate_pc) + int'(a.gate_mdr) + int'(a.gate_alu) + int'(a.gate_marmux);
      if (g > 1) begin
        n_vec++;
        n_bad++;
        $display("FAIL gate_onehot: %0d gates driving, required at most 1", g);
      end
      while (sb.size() > 0) begin
        x = sb.pop_front();
        n_vec++;
        if (a !== x.e) begin
          n_bad++;
          $display("FAIL %s: got %h required %h", x.t.name(), a, x.e);
        end else begin
          $display("vec %0d %s ok %h", n_vec, x.t.name(), a);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required run to complete");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset        = 1'b1;
    bus.Run      = 1'b0;
    bus.Continue = 1'b0;
    set_ir(4'b0000, 1'b0, 1'b0, 1'b0);
    @(posedge Clk);
    #1;
    expect_now(T_HALT);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    expect_next(T_HALT);
    expect_next(T_HALT);

    // ADD immediate
    bus.Run = 1'b1;
    set_ir(4'b0001, 1'b1, 1'b0, 1'b0);
    expect_next(T_FMAR);
    bus.Run = 1'b0;
    fetch();
    expect_next(T_ADD);
    expect_next(T_FMAR);

    set_ir(4'b0101, 1'b0, 1'b0, 1'b0);
    fetch(); expect_next(T_AND); expect_next(T_FMAR);

    set_ir(4'b1001, 1'b1, 1'b0, 1'b0);
    fetch(); expect_next(T_NOT); expect_next(T_FMAR);

    // Branch not taken, then taken
    set_ir(4'b0000, 1'b0, 1'b0, 1'b0);
    fetch(); expect_next(T_BR); expect_next(T_FMAR);
    set_ir(4'b0000, 1'b0, 1'b0, 1'b1);
    fetch(); expect_next(T_BR); expect_next(T_BRT); expect_next(T_FMAR);

    set_ir(4'b1100, 1'b0, 1'b0, 1'b0);
    fetch(); expect_next(T_JMP); expect_next(T_FMAR);

    set_ir(4'b0100, 1'b0, 1'b1, 1'b0);
    fetch(); expect_next(T_JSR); expect_next(T_JSRPC); expect_next(T_FMAR);
    set_ir(4'b0100, 1'b0, 1'b0, 1'b0);
    fetch(); expect_next(T_JSR); expect_next(T_JSRPC); expect_next(T_FMAR);

    set_ir(4'b0110, 1'b0, 1'b0, 1'b0);
    fetch(); expect_next(T_LDRA);
    repeat (MW) expect_next(T_LDRRD);
    expect_next(T_LDRWB); expect_next(T_FMAR);

    set_ir(4'b0111, 1'b0, 1'b0, 1'b0);
    fetch(); expect_next(T_STRA); expect_next(T_STRD);
    repeat (MW) expect_next(T_STRWR);
    expect_next(T_FMAR);

    // PAUSE handshake
    set_ir(4'b1101, 1'b0, 1'b0, 1'b0);
    fetch();
    repeat (10) expect_next(T_PAUSE1);
    bus.Continue = 1'b1;
    repeat (3) expect_next(T_PAUSE2);
    bus.Continue = 1'b0;
    expect_next(T_FMAR);

    // Unimplemented opcode behaves as NOP; Run toggled here has no effect
    set_ir(4'b1111, 1'b0, 1'b0, 1'b0);
    bus.Run = 1'b1;
    fetch(); expect_next(T_FMAR);
    bus.Run = 1'b0;

    // Asynchronous reset in the middle of a memory read
    set_ir(4'b0001, 1'b0, 1'b0, 1'b0);
    expect_next(T_FRD);
    #6;
    Reset = 1'b1;
    #1;
    expect_now(T_HALT);
    @(posedge Clk);
    #1;
    expect_now(T_HALT);
    Reset = 1'b0;
    expect_next(T_HALT);
    bus.Run = 1'b1;
    expect_next(T_FMAR);
    bus.Run = 1'b0;
    fetch(); expect_next(T_ADD); expect_next(T_FMAR);

    @(negedge Clk);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
